// File: rtl/sdram_ch0_arbiter_if.sv
// Bundle of the requester handshakes and the SDRAM channel 0 signals.
// The slave modport is the arbiter's view. The master modport is the environment's view:
// the requesters plus the SDRAM controller.
interface sdram_ch0_arbiter_if #(
  parameter int unsigned ADDR_W = 25
) ();
  logic              rq0_req;
  logic              rq0_wr;
  logic [ADDR_W-1:0] rq0_addr;
  logic [7:0]        rq0_din;
  logic              rq0_ack;
  logic              rq1_req;
  logic              rq1_wr;
  logic [ADDR_W-1:0] rq1_addr;
  logic [7:0]        rq1_din;
  logic              rq1_ack;
  logic              rq2_req;
  logic              rq2_wr;
  logic [ADDR_W-1:0] rq2_addr;
  logic [7:0]        rq2_din;
  logic              rq2_ack;
  logic [7:0]        rd_data;
  logic [ADDR_W-1:0] ch0_addr;
  logic              ch0_wr;
  logic              ch0_rd;
  logic [7:0]        ch0_din;
  logic [7:0]        ch0_dout;
  logic              ch0_busy;
  logic              refresh;
  logic              err_timeout;
  logic              busy;

  modport slave (
    input  rq0_req, rq0_wr, rq0_addr, rq0_din,
    input  rq1_req, rq1_wr, rq1_addr, rq1_din,
    input  rq2_req, rq2_wr, rq2_addr, rq2_din,
    input  ch0_dout, ch0_busy,
    output rq0_ack, rq1_ack, rq2_ack, rd_data,
    output ch0_addr, ch0_wr, ch0_rd, ch0_din,
    output refresh, err_timeout, busy
  );

  modport master (
    output rq0_req, rq0_wr, rq0_addr, rq0_din,
    output rq1_req, rq1_wr, rq1_addr, rq1_din,
    output rq2_req, rq2_wr, rq2_addr, rq2_din,
    output ch0_dout, ch0_busy,
    input  rq0_ack, rq1_ack, rq2_ack, rd_data,
    input  ch0_addr, ch0_wr, ch0_rd, ch0_din,
    input  refresh, err_timeout, busy
  );
endinterface

// File: rtl/sdram_ch0_arbiter.sv
// SDRAM channel 0 arbiter.
// Three requesters share the byte-wide channel: rq0 has fixed priority, and rq1/rq2 take
// turns. The arbiter sequences each access as issue, busy wait and completion, and it
// inserts periodic auto-refresh cycles.
module sdram_ch0_arbiter #(
  parameter int unsigned ADDR_W           = 25,
  parameter int unsigned REFRESH_INTERVAL = 1024,
  parameter int unsigned REFRESH_LEN      = 4,
  parameter int unsigned ARM_CYCLES       = 2,
  parameter int unsigned BUSY_TIMEOUT     = 255
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  sdram_ch0_arbiter_if.slave bus
);
  localparam int unsigned      REF_W    = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_INTERVAL - 1);
  localparam logic [15:0]      ARM_LAST = 16'(ARM_CYCLES - 1);
  localparam logic [15:0]      WAIT_LAST = 16'(BUSY_TIMEOUT - 1);
  localparam logic [15:0]      RLEN_LAST = 16'(REFRESH_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_ARM, S_WAIT, S_ACK, S_REFRESH
  } state_t;

  state_t            state, state_n;
  logic [15:0]       step, step_n;
  logic [REF_W-1:0]  ref_cnt;
  logic              ref_pending;
  logic              ref_wrap;
  logic              ref_go;
  logic              rr_rq2;
  logic              grant;
  logic [1:0]        grant_id;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_din;
  logic              start;
  logic              take_refresh;
  logic              capture;
  logic              timeout_hit;
  logic [1:0]        cur_id;
  logic              cur_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        din_q;
  logic [7:0]        rd_q;
  logic              err_q;
  logic              strobe;

  // A wrap happening in this very cycle already beats any requester.
  assign ref_wrap = (ref_cnt == REF_LAST);
  assign ref_go   = ref_pending | ref_wrap;

  // Requester selection: rq0 first, then rq1/rq2 by round-robin pointer
  always_comb begin
    grant    = 1'b0;
    grant_id = 2'd0;
    if (bus.rq0_req) begin
      grant    = 1'b1;
      grant_id = 2'd0;
    end else if (bus.rq1_req && (!bus.rq2_req || !rr_rq2)) begin
      grant    = 1'b1;
      grant_id = 2'd1;
    end else if (bus.rq2_req) begin
      grant    = 1'b1;
      grant_id = 2'd2;
    end
  end

  // Mux of the winning requester's command fields
  always_comb begin
    sel_wr   = bus.rq0_wr;
    sel_addr = bus.rq0_addr;
    sel_din  = bus.rq0_din;
    case (grant_id)
      2'd1: begin
        sel_wr   = bus.rq1_wr;
        sel_addr = bus.rq1_addr;
        sel_din  = bus.rq1_din;
      end
      2'd2: begin
        sel_wr   = bus.rq2_wr;
        sel_addr = bus.rq2_addr;
        sel_din  = bus.rq2_din;
      end
      default: ;
    endcase
  end

  // Next-state logic and per-cycle control strobes
  always_comb begin
    state_n      = state;
    step_n       = step;
    start        = 1'b0;
    take_refresh = 1'b0;
    capture      = 1'b0;
    timeout_hit  = 1'b0;
    case (state)
      S_IDLE: begin
        step_n = '0;
        if (ref_go) begin
          take_refresh = 1'b1;
          state_n      = S_REFRESH;
        end else if (grant) begin
          start   = 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        step_n  = '0;
        state_n = S_ARM;
      end
      S_ARM: begin
        if (bus.ch0_busy || (step == ARM_LAST)) begin
          step_n  = '0;
          state_n = S_WAIT;
        end else begin
          step_n = step + 16'd1;
        end
      end
      S_WAIT: begin
        if (!bus.ch0_busy) begin
          capture = ~cur_wr;
          state_n = S_ACK;
        end else if (step == WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_n     = S_ACK;
        end else begin
          step_n = step + 16'd1;
        end
      end
      S_ACK: begin
        state_n = S_IDLE;
      end
      S_REFRESH: begin
        if (step == RLEN_LAST) begin
          step_n  = '0;
          state_n = S_IDLE;
        end else begin
          step_n = step + 16'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and phase counter registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      step  <= '0;
    end else begin
      state <= state_n;
      step  <= step_n;
    end
  end

  // Command latch at grant, read-data capture, sticky timeout flag, turn pointer
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cur_id <= '0;
      cur_wr <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      rd_q   <= '0;
      err_q  <= 1'b0;
      rr_rq2 <= 1'b0;
    end else begin
      if (start) begin
        cur_id <= grant_id;
        cur_wr <= sel_wr;
        addr_q <= sel_addr;
        din_q  <= sel_din;
        if (grant_id == 2'd1) rr_rq2 <= 1'b1;
        else if (grant_id == 2'd2) rr_rq2 <= 1'b0;
      end
      if (capture) rd_q <= bus.ch0_dout;
      if (timeout_hit) err_q <= 1'b1;
    end
  end

  // Free-running refresh interval counter and pending flag
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
    end else begin
      ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
      if (take_refresh) ref_pending <= 1'b0;
      else if (ref_wrap) ref_pending <= 1'b1;
    end
  end

  // The strobe stays up from ISSUE through WAIT, so it drops on entry to ACK.
  assign strobe = (state == S_ISSUE) || (state == S_ARM) || (state == S_WAIT);

  assign bus.ch0_wr      = strobe & cur_wr;
  assign bus.ch0_rd      = strobe & ~cur_wr;
  assign bus.ch0_addr    = addr_q;
  assign bus.ch0_din     = din_q;
  assign bus.rd_data     = rd_q;
  assign bus.err_timeout = err_q;
  assign bus.refresh     = (state == S_REFRESH);
  assign bus.busy        = (state != S_IDLE);
  assign bus.rq0_ack     = (state == S_ACK) && (cur_id == 2'd0);
  assign bus.rq1_ack     = (state == S_ACK) && (cur_id == 2'd1);
  assign bus.rq2_ack     = (state == S_ACK) && (cur_id == 2'd2);
endmodule

// File: tb/tb_sdram_ch0_arbiter.sv
// Testbench for sdram_ch0_arbiter.
// A behavioural SDRAM controller drives ch0_busy and ch0_dout. Each expected
// completion (requester id, and read data for reads) is queued when a request is
// raised, and the ack monitor checks it when the ack pulses.
module tb_sdram_ch0_arbiter;
  localparam int unsigned ADDR_W = 25;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sdram_ch0_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  sdram_ch0_arbiter #(
    .ADDR_W(ADDR_W),
    .REFRESH_INTERVAL(1024),
    .REFRESH_LEN(4),
    .ARM_CYCLES(2),
    .BUSY_TIMEOUT(255)
  ) dut (
    .clk_sys(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int         id;
    logic       is_rd;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic is_rd, input logic [7:0] data);
    exp_t e;
    e.id = id;
    e.is_rd = is_rd;
    e.data = data;
    sb.push_back(e);
  endtask

  // Controller model: busy rises the cycle after a new strobe and stays high for
  // busy_len cycles. While hold_busy is set, busy is stuck high.
  logic hold_busy = 1'b0;
  int   busy_len = 1;
  int   busy_cnt;
  logic seen;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.ch0_busy <= 1'b0;
      busy_cnt     <= 0;
      seen         <= 1'b0;
    end else if (hold_busy) begin
      bus.ch0_busy <= 1'b1;
      busy_cnt     <= 0;
    end else if ((bus.ch0_wr || bus.ch0_rd) && !seen) begin
      seen         <= 1'b1;
      bus.ch0_busy <= 1'b1;
      busy_cnt     <= busy_len - 1;
    end else if (bus.ch0_busy) begin
      if (busy_cnt == 0) bus.ch0_busy <= 1'b0;
      else busy_cnt <= busy_cnt - 1;
    end else if (!(bus.ch0_wr || bus.ch0_rd)) begin
      seen <= 1'b0;
    end
  end

  // Ack monitor: pops the scoreboard on every completion pulse
  always @(negedge clk) begin : ack_mon
    logic [2:0] a;
    exp_t e;
    if (reset_n === 1'b1) begin
      a = {bus.rq2_ack, bus.rq1_ack, bus.rq0_ack};
      if (a != 3'b000) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", {29'd0, a}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("ack_id", {29'd0, a}, 32'(1 << e.id));
          if (e.is_rd) check("ack_rd_data", {24'd0, bus.rd_data}, {24'd0, e.data});
        end
      end
    end
  end

  task automatic wait_any(input int budget, input string tag);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.rq0_ack || bus.rq1_ack || bus.rq2_ack) return;
    end
    check(tag, 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int   n, wr_cyc, rd_cyc, bsy_cyc, ref_cyc, first_ref, len;
  logic got, rd_seen, prev, err_at_ack;

  initial begin
    reset_n = 1'b0;
    bus.rq0_req = 1'b0; bus.rq0_wr = 1'b0; bus.rq0_addr = '0; bus.rq0_din = '0;
    bus.rq1_req = 1'b0; bus.rq1_wr = 1'b0; bus.rq1_addr = '0; bus.rq1_din = '0;
    bus.rq2_req = 1'b0; bus.rq2_wr = 1'b0; bus.rq2_addr = '0; bus.rq2_din = '0;
    bus.ch0_dout = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_ch0_wr", {31'd0, bus.ch0_wr}, 32'd0);
    check("rst_ch0_rd", {31'd0, bus.ch0_rd}, 32'd0);
    check("rst_ch0_addr", {7'd0, bus.ch0_addr}, 32'd0);
    check("rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
    check("rst_refresh", {31'd0, bus.refresh}, 32'd0);
    check("rst_err", {31'd0, bus.err_timeout}, 32'd0);
    check("rst_acks", {29'd0, bus.rq2_ack, bus.rq1_ack, bus.rq0_ack}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write from rq1, busy held 3 cycles
    busy_len = 3;
    bus.rq1_wr = 1'b1; bus.rq1_addr = 25'h2000; bus.rq1_din = 8'h01; bus.rq1_req = 1'b1;
    push_exp(1, 1'b0, 8'h00);
    n = 0; wr_cyc = 0; bsy_cyc = 0; got = 1'b0; rd_seen = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (bus.ch0_wr) wr_cyc++;
      if (bus.ch0_busy) bsy_cyc++;
      if (bus.ch0_rd) rd_seen = 1'b1;
      if (k == 1) check("t1_busy_issue", {31'd0, bus.busy}, 32'd1);
      if (bus.busy) begin
        check("t1_addr", {7'd0, bus.ch0_addr}, 32'h2000);
        check("t1_din", {24'd0, bus.ch0_din}, 32'h01);
      end
      if (bus.rq1_ack) begin
        got = 1'b1;
        n = k;
      end
    end
    bus.rq1_req = 1'b0;
    check("t1_latency", n, 6);
    check("t1_wr_cycles", wr_cyc, 5);
    check("t1_busy_cycles", bsy_cyc, 3);
    check("t1_no_rd", {31'd0, rd_seen}, 32'd0);
    @(negedge clk);
    check("t1_ack_single", {31'd0, bus.rq1_ack}, 32'd0);
    check("t1_idle", {31'd0, bus.busy}, 32'd0);

    // Read from rq2 returning 0xA5, minimum latency
    busy_len = 1;
    bus.ch0_dout = 8'hA5;
    bus.rq2_wr = 1'b0; bus.rq2_addr = 25'h0008; bus.rq2_req = 1'b1;
    push_exp(2, 1'b1, 8'hA5);
    n = 0; got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (bus.busy) check("t2_addr", {7'd0, bus.ch0_addr}, 32'h0008);
      if (bus.rq2_ack) begin
        got = 1'b1;
        n = k;
      end
    end
    bus.rq2_req = 1'b0;
    check("t2_latency", n, 4);
    bus.ch0_dout = 8'h3C;
    repeat (4) @(negedge clk);
    check("t2_rd_hold", {24'd0, bus.rd_data}, 32'hA5);

    // Priority then round-robin with all requests held
    bus.rq0_wr = 1'b1; bus.rq0_addr = 25'h10; bus.rq0_din = 8'h10;
    bus.rq1_wr = 1'b1; bus.rq1_addr = 25'h11; bus.rq1_din = 8'h11;
    bus.rq2_wr = 1'b1; bus.rq2_addr = 25'h12; bus.rq2_din = 8'h12;
    push_exp(0, 1'b0, 8'h00);
    push_exp(1, 1'b0, 8'h00);
    push_exp(2, 1'b0, 8'h00);
    push_exp(1, 1'b0, 8'h00);
    push_exp(2, 1'b0, 8'h00);
    bus.rq0_req = 1'b1; bus.rq1_req = 1'b1; bus.rq2_req = 1'b1;
    wait_any(30, "t3_ack_wait");
    bus.rq0_req = 1'b0;
    repeat (4) wait_any(30, "t3_ack_wait");
    bus.rq1_req = 1'b0; bus.rq2_req = 1'b0;
    repeat (2) @(negedge clk);
    check("t3_sb_empty", sb.size(), 0);

    // Refresh: length, period, and a request arriving on the wrap cycle
    prev = bus.refresh; got = 1'b0;
    for (int k = 0; k < 1200 && !got; k++) begin
      @(negedge clk);
      if (bus.refresh && !prev) got = 1'b1;
      prev = bus.refresh;
    end
    check("ref_seen", {31'd0, got}, 32'd1);
    len = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.ch0_wr || bus.ch0_rd) check("ref_strobe", 32'd1, 32'd0);
      if (bus.refresh) len++;
      else break;
    end
    check("ref_len", len, 4);
    // Now at the negedge four cycles past the rising cycle; move to the start of the next wrap cycle.
    repeat (1019) @(posedge clk);
    #1;
    bus.rq1_wr = 1'b1; bus.rq1_addr = 25'h40; bus.rq1_din = 8'h09; bus.rq1_req = 1'b1;
    push_exp(1, 1'b0, 8'h00);
    n = 0; got = 1'b0; ref_cyc = 0; first_ref = 0;
    for (int k = 1; k <= 30 && !got; k++) begin
      @(negedge clk);
      if (bus.refresh) begin
        ref_cyc++;
        if (first_ref == 0) first_ref = k;
      end
      if (bus.rq1_ack) begin
        got = 1'b1;
        n = k;
      end
    end
    bus.rq1_req = 1'b0;
    check("ref_period", first_ref, 2);
    check("ref_len2", ref_cyc, 4);
    check("ref_then_rq1", n, 10);

    // Busy timeout on a read; rd_data must stay at its last value
    hold_busy = 1'b1;
    repeat (2) @(negedge clk);
    check("to_err_before", {31'd0, bus.err_timeout}, 32'd0);
    bus.ch0_dout = 8'h77;
    bus.rq0_wr = 1'b0; bus.rq0_addr = 25'h100; bus.rq0_req = 1'b1;
    push_exp(0, 1'b1, 8'hA5);
    n = 0; got = 1'b0; rd_cyc = 0; err_at_ack = 1'b0;
    for (int k = 1; k <= 400 && !got; k++) begin
      @(negedge clk);
      if (bus.ch0_rd) rd_cyc++;
      if (bus.rq0_ack) begin
        got = 1'b1;
        n = k;
        err_at_ack = bus.err_timeout;
      end
    end
    hold_busy = 1'b0;
    bus.rq0_req = 1'b0;
    check("to_latency", n, 258);
    check("to_strobe_cycles", rd_cyc, 257);
    check("to_err_at_ack", {31'd0, err_at_ack}, 32'd1);
    repeat (3) @(negedge clk);
    bus.rq2_wr = 1'b1; bus.rq2_addr = 25'h30; bus.rq2_din = 8'h44; bus.rq2_req = 1'b1;
    push_exp(2, 1'b0, 8'h00);
    wait_any(20, "to_next_ack_wait");
    bus.rq2_req = 1'b0;
    check("to_err_sticky", {31'd0, bus.err_timeout}, 32'd1);
    repeat (2) @(negedge clk);

    // Reset during WAIT: the in-flight access is dropped and the turn pointer returns to rq1
    hold_busy = 1'b1;
    bus.rq1_wr = 1'b0; bus.rq1_addr = 25'h55; bus.rq1_req = 1'b1;
    repeat (6) @(negedge clk);
    check("mr_in_wait", {30'd0, bus.busy, bus.ch0_rd}, 32'd3);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mr_busy", {31'd0, bus.busy}, 32'd0);
    check("mr_ch0_rd", {31'd0, bus.ch0_rd}, 32'd0);
    check("mr_ack", {29'd0, bus.rq2_ack, bus.rq1_ack, bus.rq0_ack}, 32'd0);
    check("mr_rd_data", {24'd0, bus.rd_data}, 32'd0);
    check("mr_err", {31'd0, bus.err_timeout}, 32'd0);
    check("mr_ch0_addr", {7'd0, bus.ch0_addr}, 32'd0);
    hold_busy = 1'b0;
    bus.ch0_dout = 8'h5A;
    bus.rq2_wr = 1'b1; bus.rq2_addr = 25'h66; bus.rq2_din = 8'h21; bus.rq2_req = 1'b1;
    @(negedge clk);
    push_exp(1, 1'b1, 8'h5A);
    push_exp(2, 1'b0, 8'h00);
    reset_n = 1'b1;
    wait_any(20, "mr_ack1_wait");
    bus.rq1_req = 1'b0;
    wait_any(20, "mr_ack2_wait");
    bus.rq2_req = 1'b0;
    repeat (3) @(negedge clk);
    check("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sdram_ch0_arbiter.md
Name: sdram_ch0_arbiter

Overview:
- Shares the single byte-wide SDRAM channel 0 between three requesters: the HPS ioctl loader, the screen-text writer and the font/screen reader.
- Owns the channel strobes and sequences each access as issue, busy wait, completion.
- Issues periodic auto-refresh requests to the SDRAM controller.
- Sits between the top-level state machines and the sdram instance, all on clk_sys.

Parameters:
- ADDR_W, 25, width of the SDRAM byte address.
- REFRESH_INTERVAL, 1024, clk_sys cycles between refresh requests.
- REFRESH_LEN, 4, cycles the refresh output is held high.
- ARM_CYCLES, 2, cycles allowed for ch0_busy to rise after a strobe.
- BUSY_TIMEOUT, 255, maximum cycles waiting for ch0_busy to fall.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rqN_req  in  1  (N = 0, 1, 2) access request; held until rqN_ack.
- rqN_wr  in  1  1 = write, 0 = read; sampled at grant.
- rqN_addr  in  ADDR_W  byte address; sampled at grant.
- rqN_din  in  8  write data; sampled at grant.
- rqN_ack  out  1  one-cycle completion pulse.
- rd_data  out  8  read data; valid in the rqN_ack cycle of a read, held until the next read completes.
- ch0_addr  out  ADDR_W  to the SDRAM controller.
- ch0_wr  out  1  to the SDRAM controller.
- ch0_rd  out  1  to the SDRAM controller.
- ch0_din  out  8  to the SDRAM controller.
- ch0_dout  in  8  read data from the controller.
- ch0_busy  in  1  controller busy.
- refresh  out  1  refresh request to the controller.
- err_timeout  out  1  sticky; set on a busy timeout.
- busy  out  1  high whenever the arbiter is not in IDLE.

Behaviour:
- Reset values: every output is 0, ch0_addr is 0, rd_data is 0, the state is IDLE, refresh is not pending, the round-robin pointer points at rq1.
- Reset acts immediately and may arrive mid-transaction; any in-flight transaction is abandoned without an ack.

Refresh counter:
- Free-running; wraps at REFRESH_INTERVAL-1.
- On wrap it sets refresh_pending. A wrap while the flag is already set is absorbed, not counted twice.

Arbitration (in IDLE only):
- Order of precedence: refresh_pending, then rq0 (fixed highest priority), then rq1/rq2 round-robin.
- After rq1 or rq2 is served, the pointer moves to the other one.
- A request that is high in the same cycle as a refresh wrap loses to the refresh.

States:
- IDLE: choose a winner using the arbitration rules. For a requester, latch addr/din/wr/id into the ch0_* registers and go to ISSUE. For a refresh, clear the flag and go to REFRESH.
- ISSUE (1 cycle): assert ch0_wr or ch0_rd (never both) and go to ARM.
- ARM: keep the strobe high. Go to WAIT when ch0_busy=1 or after ARM_CYCLES cycles, whichever comes first.
- WAIT: keep the strobe high while ch0_busy=1. When ch0_busy=0, deassert the strobe, capture ch0_dout into rd_data if the access is a read, and go to ACK. If the wait counter reaches BUSY_TIMEOUT, deassert the strobe, set err_timeout, leave rd_data unchanged, and go to ACK.
- ACK (1 cycle): pulse ack for the granted requester and return to IDLE.
- REFRESH: hold refresh high for REFRESH_LEN cycles, then return to IDLE; the strobes stay low throughout.

Timing and protocol rules:
- Minimum latency from req to ack with busy dropping immediately is 5 cycles: IDLE, ISSUE, ARM, WAIT, ACK.
- A new grant cannot happen before the cycle after ACK, so back-to-back requests are spaced at least 5 cycles apart.
- ch0_addr and ch0_din are stable from ISSUE through ACK.
- A req that falls before its ack has no effect: the transaction completes and the ack still pulses.
- Input changes after grant are ignored.
- busy is high in every state except IDLE.

Test Plan:
- Single write, no contention: rq1 writes addr 0x2000, data 0x01; busy is high for 3 cycles. Check that ch0_wr is high from ISSUE until busy falls, that rq1_ack pulses once, and that ch0_addr stays 0x2000 throughout.
- Read data return: rq2 reads addr 0x0008 and the model returns 0xA5. Check that rd_data = 0xA5 in the rq2_ack cycle and is held afterwards.
- Priority and round-robin: rq0, rq1 and rq2 are all held high continuously. The required grant order is rq0, rq1, rq2, rq1, rq2 once rq0 is dropped after its ack.
- Refresh: with no requests, refresh rises every 1024 cycles for 4 cycles. When rq1 asserts in the same cycle as the wrap, the refresh runs first and rq1 is granted afterwards.
- Timeout: ch0_busy is held at 1. Check that err_timeout sets after 255 WAIT cycles, that the ack still pulses, and that the next transaction proceeds with err_timeout remaining set.
- Reset mid-operation: assert reset_n=0 during WAIT. Outputs must go to 0 in the same cycle with no ack; after release, the first grant goes to rq1 when rq1 and rq2 are both pending.
